// File: rtl/core_pkg.sv
// core_pkg: shared ID/EX state encoding, default widths and id_ctrl field offsets
package core_pkg;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam int DATA_WIDTH_D     = 32;
  localparam int REG_ADDR_WIDTH_D = 5;
  localparam int ALU_CTRL_WIDTH_D = 4;
  localparam int FLOW_WIDTH_D     = 4;
  localparam int FLOW_LSB         = 0;
  function automatic int alu_src_bit(input int flow_w);
    return flow_w;
  endfunction
  function automatic int alu_ctrl_lsb(input int flow_w);
    return flow_w + 1;
  endfunction
endpackage

// File: rtl/id_ex_slot.sv
// id_ex_slot: payload register with load and synchronous clear
module id_ex_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (ld) q <= d;
endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX boundary with valid/ready handshake, one-entry skid buffer and flush
module id_ex_pipe import core_pkg::*; #(
  parameter int DATA_WIDTH     = DATA_WIDTH_D,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_D,
  parameter int ALU_CTRL_WIDTH = ALU_CTRL_WIDTH_D,
  parameter int FLOW_WIDTH     = FLOW_WIDTH_D
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic                                   id_valid,
  output logic                                   id_ready,
  input  logic [DATA_WIDTH-1:0]                  id_pc,
  input  logic [DATA_WIDTH-1:0]                  id_rs1_data,
  input  logic [DATA_WIDTH-1:0]                  id_rs2_data,
  input  logic [DATA_WIDTH-1:0]                  id_imm,
  input  logic [ALU_CTRL_WIDTH+FLOW_WIDTH:0]     id_ctrl,
  input  logic [REG_ADDR_WIDTH-1:0]              id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]              id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0]              id_rd,
  output logic                                   ex_valid,
  input  logic                                   ex_ready,
  output logic [DATA_WIDTH-1:0]                  ex_pc,
  output logic [DATA_WIDTH-1:0]                  ex_rs1_data,
  output logic [DATA_WIDTH-1:0]                  ex_rs2_data,
  output logic [DATA_WIDTH-1:0]                  ex_imm,
  output logic [ALU_CTRL_WIDTH-1:0]              ex_alu_ctrl,
  output logic                                   ex_alu_src,
  output logic [FLOW_WIDTH-1:0]                  ex_flow,
  output logic [REG_ADDR_WIDTH-1:0]              ex_rs1,
  output logic [REG_ADDR_WIDTH-1:0]              ex_rs2,
  output logic [REG_ADDR_WIDTH-1:0]              ex_rd
);
  localparam int CW  = ALU_CTRL_WIDTH + FLOW_WIDTH + 1;
  localparam int PW  = 4*DATA_WIDTH + 3*REG_ADDR_WIDTH + CW;
  localparam int SRC = alu_src_bit(FLOW_WIDTH);
  localparam int ALU = alu_ctrl_lsb(FLOW_WIDTH);
  logic [1:0] state, state_n;
  logic in_fire, out_fire, main_ld, skid_ld;
  logic [PW-1:0] in_pl, main_d, main_pl, skid_pl;
  logic [REG_ADDR_WIDTH-1:0] m_rd;
  logic [CW-1:0] m_ctrl;
  assign in_fire  = id_valid & id_ready;
  assign out_fire = ex_valid & ex_ready;
  assign ex_valid = state != ST_EMPTY;
  assign in_pl    = {id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_ctrl};
  always_comb begin
    state_n = flush ? ST_EMPTY :
              state == ST_EMPTY ? (in_fire ? ST_BUSY : ST_EMPTY) :
              state == ST_BUSY  ? (in_fire & !out_fire ? ST_FULL : !in_fire & out_fire ? ST_EMPTY : ST_BUSY) :
              (out_fire ? ST_BUSY : ST_FULL);
    main_ld = !flush & (state == ST_FULL ? out_fire : in_fire & (state == ST_EMPTY | out_fire));
    skid_ld = !flush & (state == ST_BUSY) & in_fire & !out_fire;
    main_d  = state == ST_FULL ? skid_pl : in_pl;
  end
  // id_ready is registered from next state so ex_ready never reaches it combinationally
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= ST_EMPTY;
      id_ready <= 1'b1;
    end else begin
      state    <= state_n;
      id_ready <= state_n != ST_FULL;
    end
  id_ex_slot #(.W(PW)) u_main (.clk, .rst, .clr(flush), .ld(main_ld), .d(main_d), .q(main_pl));
  id_ex_slot #(.W(PW)) u_skid (.clk, .rst, .clr(flush), .ld(skid_ld), .d(in_pl), .q(skid_pl));
  assign {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, m_rd, m_ctrl} = main_pl;
  // bubbles must not enable any downstream write or memory access
  assign ex_rd       = ex_valid ? m_rd : '0;
  assign ex_alu_ctrl = ex_valid ? m_ctrl[ALU +: ALU_CTRL_WIDTH] : '0;
  assign ex_alu_src  = ex_valid & m_ctrl[SRC];
  assign ex_flow     = ex_valid ? m_ctrl[FLOW_LSB +: FLOW_WIDTH] : '0;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: randomized scenarios checked against a two-deep queue model of the boundary
module tb_id_ex_pipe;
  typedef struct packed {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [8:0]  ctrl;
  } ins_t;
  logic clk = 0, rst = 1, flush = 0, id_valid = 0, ex_ready = 0;
  logic id_ready, ex_valid, ex_alu_src;
  logic [31:0] id_pc = 0, id_rs1_data = 0, id_rs2_data = 0, id_imm = 0;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [8:0] id_ctrl = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0, ex_rs1, ex_rs2, ex_rd;
  logic [3:0] ex_alu_ctrl, ex_flow;
  int checks = 0, errors = 0;
  ins_t mq[$];
  logic [4:0] out_log[$];
  always #5 clk = ~clk;
  id_ex_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_src(ex_alu_src),
    .ex_flow(ex_flow), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd)
  );
  function automatic ins_t rnd_ins();
    ins_t i;
    i = {$urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 9'($urandom)};
    return i;
  endfunction
  function automatic ins_t rd_ins(input logic [4:0] rd);
    ins_t i = rnd_ins();
    i.rd = rd;
    return i;
  endfunction
  function automatic ins_t observed();
    ins_t o = {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_alu_ctrl, ex_alu_src, ex_flow};
    return o;
  endfunction
  // Called at a negedge: drive, compare against the model, clock once, advance the model.
  task automatic cycle(input logic v, input ins_t i, input logic er, input logic fl);
    ins_t obs;
    logic f_in, f_out;
    id_valid = v; ex_ready = er; flush = fl;
    {id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_ctrl} = i;
    #1;
    obs = observed();
    checks++;
    if (ex_valid !== (mq.size() > 0) || id_ready !== (mq.size() < 2)) begin
      errors++;
      $display("FAIL handshake t=%0t ex_valid=%b id_ready=%b required %b %b", $time, ex_valid, id_ready, mq.size() > 0, mq.size() < 2);
    end
    checks++;
    if (mq.size() > 0) begin
      if (obs !== mq[0]) begin
        errors++;
        $display("FAIL payload t=%0t got %h required %h", $time, obs, mq[0]);
      end
    end else if ({obs.rd, obs.ctrl} !== 14'd0) begin
      errors++;
      $display("FAIL bubble t=%0t rd=%h ctrl=%h required 0", $time, obs.rd, obs.ctrl);
    end
    f_in  = v && mq.size() < 2;
    f_out = er && mq.size() > 0;
    if (f_out) out_log.push_back(obs.rd);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (f_out) void'(mq.pop_front());
      if (f_in) mq.push_back(i);
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, rnd_ins(), 1, 0);
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if (ex_valid !== 0 || id_ready !== 1 || observed() !== '0) begin
      errors++;
      $display("FAIL reset ex_valid=%b id_ready=%b outs=%h required 0 1 0", ex_valid, id_ready, observed());
    end
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_streaming();
    ins_t sent[8];
    out_log.delete();
    for (int k = 0; k < 8; k++) begin
      sent[k] = rnd_ins();
      cycle(1, sent[k], 1, 0);
      checks++;
      if (id_ready !== 1 || ex_valid !== 1) begin
        errors++;
        $display("FAIL stream_ready k=%0d id_ready=%b ex_valid=%b required 1 1", k, id_ready, ex_valid);
      end
    end
    idle(2);
    checks++;
    if (out_log.size() != 8) begin
      errors++;
      $display("FAIL stream_count got %0d required 8", out_log.size());
    end else for (int k = 0; k < 8; k++) if (out_log[k] !== sent[k].rd) begin
      errors++;
      $display("FAIL stream_order k=%0d got %0d required %0d", k, out_log[k], sent[k].rd);
    end
  endtask
  task automatic test_stall();
    ins_t r3 = rd_ins(3);
    out_log.delete();
    cycle(1, rd_ins(1), 0, 0);
    cycle(1, rd_ins(2), 0, 0);
    cycle(1, r3, 0, 0);
    checks++;
    if (ex_rd !== 5'd1 || id_ready !== 0 || ex_valid !== 1) begin
      errors++;
      $display("FAIL stall_hold ex_rd=%0d id_ready=%b ex_valid=%b required 1 0 1", ex_rd, id_ready, ex_valid);
    end
    cycle(1, r3, 1, 0);
    cycle(1, r3, 1, 0);
    idle(2);
    checks++;
    if (out_log.size() != 3 || out_log[0] !== 5'd1 || out_log[1] !== 5'd2 || out_log[2] !== 5'd3) begin
      errors++;
      $display("FAIL stall_order got %p required 1 2 3", out_log);
    end
  endtask
  task automatic test_flush_full();
    out_log.delete();
    cycle(1, rd_ins(4), 0, 0);
    cycle(1, rd_ins(5), 0, 0);
    cycle(1, rd_ins(7), 0, 1);
    checks++;
    if (ex_valid !== 0 || ex_rd !== 0 || ex_flow !== 0 || id_ready !== 1) begin
      errors++;
      $display("FAIL flush ex_valid=%b ex_rd=%0d ex_flow=%h id_ready=%b required 0 0 0 1", ex_valid, ex_rd, ex_flow, id_ready);
    end
    idle(3);
    checks++;
    if (out_log.size() != 0) begin
      errors++;
      $display("FAIL flush_leak got %0d outputs required 0", out_log.size());
    end
  endtask
  task automatic test_ctrl_split();
    ins_t i = rnd_ins();
    i.ctrl = 9'b1010_1_0110;
    cycle(1, i, 1, 0);
    checks++;
    if (ex_alu_ctrl !== 4'b1010 || ex_alu_src !== 1 || ex_flow !== 4'b0110) begin
      errors++;
      $display("FAIL ctrl_split alu=%b src=%b flow=%b required 1010 1 0110", ex_alu_ctrl, ex_alu_src, ex_flow);
    end
    idle(1);
  endtask
  task automatic test_async_reset();
    ins_t f = rnd_ins();
    cycle(1, rnd_ins(), 0, 0);
    cycle(1, rnd_ins(), 0, 0);
    #2 rst = 1;
    #1;
    checks++;
    if (ex_valid !== 0 || id_ready !== 1 || observed() !== '0) begin
      errors++;
      $display("FAIL async_reset ex_valid=%b id_ready=%b outs=%h required 0 1 0", ex_valid, id_ready, observed());
    end
    mq.delete();
    @(negedge clk);
    rst = 0;
    cycle(1, f, 0, 0);
    checks++;
    if (ex_valid !== 1 || observed() !== f) begin
      errors++;
      $display("FAIL post_reset ex_valid=%b got %h required 1 %h", ex_valid, observed(), f);
    end
    idle(2);
  endtask
  task automatic test_drain();
    ins_t i = rnd_ins();
    i.ctrl[8:5] = 4'hF; i.ctrl[3:0] = 4'hF; i.rd = 5'd9;
    cycle(1, i, 1, 0);
    checks++;
    if (ex_valid !== 1) begin
      errors++;
      $display("FAIL drain_valid got %b required 1", ex_valid);
    end
    cycle(0, rnd_ins(), 1, 0);
    checks++;
    if (ex_valid !== 0 || ex_alu_ctrl !== 0 || ex_flow !== 0 || ex_rd !== 0) begin
      errors++;
      $display("FAIL drain_inert ex_valid=%b alu=%h flow=%h rd=%0d required 0 0 0 0", ex_valid, ex_alu_ctrl, ex_flow, ex_rd);
    end
  endtask
  task automatic test_random();
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(3) != 0, rnd_ins(), $urandom_range(2) != 0, $urandom_range(15) == 0);
    idle(3);
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_streaming();
    test_stall();
    test_flush_full();
    test_ctrl_split();
    test_async_reset();
    test_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
